// File: rtl/particle_flight_pkg.sv
// Shared game constants and types for the particle trajectory engine.
package particle_flight_pkg;

    localparam bit PLAYER_1 = 1'b1;
    localparam bit PLAYER_2 = 1'b0;

    localparam int PARTICLE_SIZE   = 50;
    localparam int PLAYER_W        = 128;
    localparam int PLAYER_H        = 144;
    localparam int CAT_SPRITE_X    = 112;
    localparam int DOG_SPRITE_X    = 762;
    localparam int PLAYER_SPRITE_Y = 455;
    localparam int FENCE           = 384;
    localparam int SCREEN_X_MAX    = 974;

    localparam int FENCE_X_START = 492;
    localparam int FENCE_X_END   = 532;
    localparam int GROUND_Y      = 743;

    localparam int CAT_LAUNCH_X = 240;
    localparam int DOG_LAUNCH_X = 712;
    localparam int LAUNCH_Y     = 405;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } flight_state_t;

    typedef enum logic [1:0] {
        OUT_NONE  = 2'd0,
        OUT_HIT   = 2'd1,
        OUT_FENCE = 2'd2,
        OUT_MISS  = 2'd3
    } outcome_t;

endpackage

// File: rtl/particle_flight_if.sv
// Throw request and particle status bundle between game logic and the flight engine.
interface particle_flight_if;
    logic        frame_tick;
    logic        throw;
    logic        turn;
    logic [4:0]  power;
    logic [3:0]  wind;
    logic        busy;
    logic        visible;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic [1:0]  outcome;
    logic        done;

    modport master (
        output frame_tick, throw, turn, power, wind,
        input  busy, visible, xpos, ypos, outcome, done
    );

    modport slave (
        input  frame_tick, throw, turn, power, wind,
        output busy, visible, xpos, ypos, outcome, done
    );
endinterface

// File: rtl/particle_flight_box_overlap.sv
// Half-open rectangle overlap between a W x H particle and a box [x0,x1) x [y0,y1).
module box_overlap #(
    parameter int W = 50,
    parameter int H = 50
) (
    input  logic signed [11:0] px_i,
    input  logic signed [11:0] py_i,
    input  logic signed [11:0] bx0_i,
    input  logic signed [11:0] bx1_i,
    input  logic signed [11:0] by0_i,
    input  logic signed [11:0] by1_i,
    output logic               hit_o
);
    localparam logic signed [12:0] WS = 13'(W);
    localparam logic signed [12:0] HS = 13'(H);

    // One extra bit so px+W cannot wrap near the top of the 12-bit range.
    logic signed [12:0] px, py, bx0, bx1, by0, by1;

    assign px  = {px_i[11], px_i};
    assign py  = {py_i[11], py_i};
    assign bx0 = {bx0_i[11], bx0_i};
    assign bx1 = {bx1_i[11], bx1_i};
    assign by0 = {by0_i[11], by0_i};
    assign by1 = {by1_i[11], by1_i};

    assign hit_o = (px + WS > bx0) && (px < bx1) && (py + HS > by0) && (py < by1);
endmodule

// File: rtl/particle_flight.sv
// Ballistic particle engine: one position step per frame, then a one-cycle collision check.
//   state  | meaning
//   IDLE   | waiting for a throw; outcome of the last flight held
//   FLIGHT | waiting for frame_tick to step the position
//   CHECK  | classify the freshly stepped position
//   DONE   | pulse done with the outcome, then back to IDLE
module particle_flight
    import particle_flight_pkg::*;
#(
    parameter int X_SPEED = 4,
    parameter int GRAVITY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    particle_flight_if.slave    bus
);
    localparam logic signed [6:0]  XS         = 7'(X_SPEED);
    localparam logic signed [8:0]  GRAV       = 9'(GRAVITY);
    localparam logic signed [11:0] CAT_X0     = 12'(CAT_LAUNCH_X);
    localparam logic signed [11:0] DOG_X0     = 12'(DOG_LAUNCH_X);
    localparam logic signed [11:0] LAUNCH_Y0  = 12'(LAUNCH_Y);
    localparam logic signed [11:0] GROUND_TOP = 12'(GROUND_Y - PARTICLE_SIZE);
    localparam logic signed [11:0] X_MAX      = 12'(SCREEN_X_MAX);

    flight_state_t      state_q, state_d;
    outcome_t           outcome_q, outcome_d;
    logic signed [11:0] x_q, x_d, y_q, y_d;
    logic signed [8:0]  vy_q, vy_d;
    logic [4:0]         vx_q, vx_d;
    logic               cat_q, cat_d;

    logic signed [6:0]  wind_ext, vx_raw;
    logic [4:0]         vx_launch;
    logic signed [11:0] vx_ext, vy_ext, tgt_x0, tgt_x1;
    logic               hit_target, hit_fence, on_ground, off_screen;

    assign wind_ext  = {{3{bus.wind[3]}}, bus.wind};
    assign vx_raw    = (bus.turn == PLAYER_2) ? XS - wind_ext : XS + wind_ext;
    assign vx_launch = (vx_raw < 7'sd1) ? 5'd1 : vx_raw[4:0];

    assign vx_ext = {7'b0, vx_q};
    assign vy_ext = {{3{vy_q[8]}}, vy_q};

    // The cat aims at the dog's box and vice versa.
    assign tgt_x0 = cat_q ? 12'(DOG_SPRITE_X) : 12'(CAT_SPRITE_X);
    assign tgt_x1 = cat_q ? 12'(DOG_SPRITE_X + PLAYER_W) : 12'(CAT_SPRITE_X + PLAYER_W);

    box_overlap #(.W(PARTICLE_SIZE), .H(PARTICLE_SIZE)) u_target (
        .px_i (x_q), .py_i (y_q),
        .bx0_i(tgt_x0), .bx1_i(tgt_x1),
        .by0_i(12'(PLAYER_SPRITE_Y)), .by1_i(12'(PLAYER_SPRITE_Y + PLAYER_H)),
        .hit_o(hit_target)
    );

    // The fence runs down to the bottom of the coordinate space.
    box_overlap #(.W(PARTICLE_SIZE), .H(PARTICLE_SIZE)) u_fence (
        .px_i (x_q), .py_i (y_q),
        .bx0_i(12'(FENCE_X_START)), .bx1_i(12'(FENCE_X_END)),
        .by0_i(12'(FENCE)), .by1_i(12'sh7FF),
        .hit_o(hit_fence)
    );

    assign on_ground  = (y_q >= GROUND_TOP);
    assign off_screen = (x_q < 12'sd0) || (x_q > X_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            outcome_q <= OUT_NONE;
            x_q       <= '0;
            y_q       <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            cat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            outcome_q <= outcome_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            cat_q     <= cat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        outcome_d = outcome_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        cat_d     = cat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.throw) begin
                    cat_d     = (bus.turn == PLAYER_1);
                    x_d       = (bus.turn == PLAYER_1) ? CAT_X0 : DOG_X0;
                    y_d       = LAUNCH_Y0;
                    vy_d      = {4'b0, bus.power};
                    vx_d      = vx_launch;
                    outcome_d = OUT_NONE;
                    state_d   = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (bus.frame_tick) begin
                    x_d     = cat_q ? x_q + vx_ext : x_q - vx_ext;
                    y_d     = y_q - vy_ext;
                    vy_d    = vy_q - GRAV;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
                if (hit_target)                outcome_d = OUT_HIT;
                else if (hit_fence)            outcome_d = OUT_FENCE;
                else if (on_ground || off_screen) outcome_d = OUT_MISS;
                else                           state_d   = S_FLIGHT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy    = (state_q == S_FLIGHT) || (state_q == S_CHECK);
    assign bus.visible = bus.busy && !y_q[11];
    assign bus.xpos    = x_q[10:0];
    assign bus.ypos    = y_q[10:0];
    assign bus.outcome = outcome_q;
    assign bus.done    = (state_q == S_DONE);
endmodule
